// File: rtl/core_ctrl_pkg.sv
// rtl/core_ctrl_pkg.sv - shared state encoding, phase indices and defaults for core control
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_IF   = 3'd1,
    ST_ID   = 3'd2,
    ST_EX   = 3'd3,
    ST_MEM  = 3'd4,
    ST_WB   = 3'd5
  } state_t;

  localparam int PH_IF  = 0;
  localparam int PH_ID  = 1;
  localparam int PH_EX  = 2;
  localparam int PH_MEM = 3;
  localparam int PH_WB  = 4;
  localparam int PH_W   = 5;

  localparam int DEF_CNT_W    = 32;
  localparam int DEF_WAIT_MAX = 15;
  localparam int DEF_WAIT_W   = 4;

  // One-hot phase strobe for a state; IDLE maps to all zeros.
  function automatic logic [PH_W-1:0] phase_of(input state_t s);
    logic [PH_W-1:0] p;
    p = '0;
    case (s)
      ST_IF:   p[PH_IF]  = 1'b1;
      ST_ID:   p[PH_ID]  = 1'b1;
      ST_EX:   p[PH_EX]  = 1'b1;
      ST_MEM:  p[PH_MEM] = 1'b1;
      ST_WB:   p[PH_WB]  = 1'b1;
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts unanswered memory ticks and flags a timeout
module mem_wait_timer
  import core_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = DEF_WAIT_MAX,
  parameter int WAIT_W   = DEF_WAIT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic tick,
  input  logic ready,
  output logic expire
);

  // Value held after WAIT_MAX-1 unanswered ticks; one more unanswered tick expires.
  localparam logic [WAIT_W-1:0] LAST = WAIT_W'(WAIT_MAX - 1);

  logic [WAIT_W-1:0] count;

  // A ready on the final tick still wins: expire requires ready low.
  assign expire = active & tick & ~ready & (count == LAST);

  // Count unanswered ticks; clear outside a wait phase, on handshake and on expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!active) begin
      count <= '0;
    end else if (tick) begin
      if (ready || expire) begin
        count <= '0;
      end else begin
        count <= count + WAIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - IF/ID/EX/MEM/WB instruction phase FSM with counters
module phase_sequencer
  import core_ctrl_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int WAIT_MAX = DEF_WAIT_MAX,
  parameter int WAIT_W   = DEF_WAIT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_en,
  input  logic             run,
  input  logic             needs_mem,
  input  logic             needs_wb,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic [PH_W-1:0]  phase,
  output logic             ir_load,
  output logic             pc_update,
  output logic             retire,
  output logic             halted,
  output logic             timeout_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  state_t state;
  logic   nm_q;
  logic   nw_q;
  logic   wait_active;
  logic   wait_expire;
  logic   do_retire;

  // Strobes come straight off the state register, so they change only at clock edges.
  assign wait_active = (state == ST_IF) || (state == ST_MEM);
  assign mem_req     = wait_active;
  assign phase       = phase_of(state);
  assign halted      = (state == ST_IDLE);

  mem_wait_timer #(
    .WAIT_MAX (WAIT_MAX),
    .WAIT_W   (WAIT_W)
  ) u_wait (
    .clk    (clk),
    .rst    (rst),
    .active (wait_active),
    .tick   (step_en),
    .ready  (mem_ready),
    .expire (wait_expire)
  );

  // Identify the tick on which the current instruction completes.
  always_comb begin
    do_retire = 1'b0;
    if (step_en) begin
      case (state)
        ST_EX:   do_retire = !nm_q && !nw_q;
        ST_MEM:  do_retire = mem_ready && !nw_q;
        ST_WB:   do_retire = 1'b1;
        default: do_retire = 1'b0;
      endcase
    end
  end

  // Phase FSM, decode latches, pulse outputs and counters; all advance only on step_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      nm_q        <= 1'b0;
      nw_q        <= 1'b0;
      ir_load     <= 1'b0;
      pc_update   <= 1'b0;
      retire      <= 1'b0;
      timeout_err <= 1'b0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      ir_load   <= 1'b0;
      pc_update <= 1'b0;
      retire    <= 1'b0;
      if (step_en) begin
        if (state != ST_IDLE) begin
          cycle_cnt <= cycle_cnt + CNT_W'(1);
        end
        if (do_retire) begin
          retire      <= 1'b1;
          pc_update   <= 1'b1;
          instret_cnt <= instret_cnt + CNT_W'(1);
          state       <= run ? ST_IF : ST_IDLE;
        end else begin
          case (state)
            ST_IDLE: begin
              if (run && !timeout_err) state <= ST_IF;
            end
            ST_IF: begin
              if (mem_ready) begin
                state   <= ST_ID;
                ir_load <= 1'b1;
              end else if (wait_expire) begin
                timeout_err <= 1'b1;
                state       <= ST_IDLE;
              end
            end
            ST_ID: begin
              nm_q  <= needs_mem;
              nw_q  <= needs_wb;
              state <= ST_EX;
            end
            ST_EX: begin
              state <= nm_q ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
              if (mem_ready) begin
                state <= ST_WB;
              end else if (wait_expire) begin
                timeout_err <= 1'b1;
                state       <= ST_IDLE;
              end
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Sits directly downstream of clock_gen in the multi-cycle RV32I core.
- Consumes the step_en tick produced by clock_gen and drives the instruction-phase FSM: IF, ID, EX, MEM, WB.
- Emits one-hot phase strobes, a memory request/ready handshake, and the IR-load, PC-update and retire pulses.
- Keeps cycle and retired-instruction counters for the datapath and control.

Parameters:
- CNT_W, 32, width of cycle_cnt and instret_cnt.
- WAIT_MAX, 15, maximum number of step_en ticks spent waiting for mem_ready in IF or MEM before a timeout.
- WAIT_W, 4, width of the wait counter; must satisfy WAIT_W >= clog2(WAIT_MAX+1).

Ports:
- clk  in  1  core clock, the same net that drives clock_gen.
- rst  in  1  asynchronous active-high reset.
- step_en  in  1  phase-advance tick from clock_gen; state changes only on edges where step_en=1.
- run  in  1  level; 1 = execute instructions, 0 = stop at the next instruction boundary.
- needs_mem  in  1  from decode; sampled in ID.
- needs_wb  in  1  from decode; sampled in ID.
- mem_ready  in  1  memory handshake completion.
- mem_req  out  1  memory request, held for the whole of IF and MEM.
- phase  out  5  one-hot {WB,MEM,EX,ID,IF}; 0 in IDLE.
- ir_load  out  1  one-clk pulse on the edge that leaves IF.
- pc_update  out  1  one-clk pulse on the edge that retires.
- retire  out  1  one-clk pulse per completed instruction.
- halted  out  1  1 in IDLE.
- timeout_err  out  1  sticky memory-timeout flag.
- cycle_cnt  out  CNT_W  count of step_en ticks while not IDLE.
- instret_cnt  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, phase=0, halted=1.
  - mem_req, ir_load, pc_update, retire, timeout_err = 0.
  - Both counters = 0; wait counter = 0; latched needs_mem/needs_wb = 0.
  - Asserting rst mid-instruction aborts it; no retire pulse is produced.
- All transitions require step_en=1 on the clk edge. With step_en=0 everything holds, and the pulse outputs are 0 on the following cycle.
- IDLE:
  - run=1 and timeout_err=0 -> IF.
  - Otherwise stay in IDLE.
- IF:
  - mem_req=1.
  - mem_ready=1 -> ID, with ir_load pulsing for one clk.
  - mem_ready=0 -> stay and increment the wait counter.
- ID:
  - Latch needs_mem and needs_wb.
  - Always -> EX.
- EX:
  - latched needs_mem -> MEM.
  - Else latched needs_wb -> WB.
  - Else retire here: pulse retire and pc_update, then go to IF if run=1, or IDLE if run=0.
- MEM:
  - mem_req=1; waits on mem_ready exactly as IF does.
  - On completion -> WB if latched needs_wb, else retire as described for EX.
- WB:
  - Always retire, then go to IF or IDLE according to run.
- Retire:
  - retire and pc_update are high for exactly one clk.
  - instret_cnt increments by 1 on the same edge, wrapping mod 2^CNT_W.
- Wait counter:
  - Clears on entry to IF/MEM and on handshake completion.
  - Wait ticks are counted only when step_en=1 and mem_ready=0.
  - When it reaches WAIT_MAX: timeout_err<=1, state<=IDLE, mem_req drops, no retire.
  - mem_ready=1 on the same edge as the WAIT_MAX-th tick completes the handshake; it is not a timeout.
  - timeout_err clears only on rst.
- cycle_cnt increments on every step_en edge where state != IDLE, wrapping mod 2^CNT_W.
- run is only examined in IDLE and at retire. Dropping run mid-instruction finishes that instruction.
- Outputs are registered. phase and mem_req are decoded from the state register, so neither has a glitch nor an extra cycle of latency.
- needs_mem and needs_wb are ignored outside ID.

Decomposition:
- Shared package core_ctrl_pkg:
  - state enum IDLE/IF/ID/EX/MEM/WB.
  - phase bit indices.
  - default CNT_W and WAIT_MAX.
- One natural sub-module: mem_wait_timer (wait counter plus timeout compare), reused by the future bus bridge.

Test Plan:
- Reset then run=1, step_en=1 every clk, mem_ready=1, ALU op (needs_mem=0, needs_wb=1) -> phase sequence IF,ID,EX,WB; retire on the 4th edge; instret_cnt=1, cycle_cnt=4.
- Load (needs_mem=1, needs_wb=1), mem_ready low for 3 ticks in MEM -> MEM held for 4 ticks, mem_req stays high throughout, retire after WB, cycle_cnt=8.
- Branch (needs_mem=0, needs_wb=0), step_en every 3rd clk -> EX retires directly with no WB; phase holds between ticks; retire is a single clk wide.
- mem_ready=0 in IF for 15 ticks -> timeout_err=1, halted=1, mem_req=0, instret_cnt unchanged; run=1 afterwards stays in IDLE.
- run dropped during EX of a store -> MEM completes and the instruction retires once, then IDLE with halted=1.
- rst asserted mid-MEM without a clk edge -> all outputs reach their reset values immediately; counters=0.
